// File: rtl/omsp_sha512_padder.sv
// omsp_sha512_padder: packs 16-bit halfwords big-endian into 64-bit SHA-512 message words
// and appends the 1-bit marker, zero fill and 128-bit bit-length as 16-word blocks.
module omsp_sha512_padder #(
    parameter int LEN_W = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        in_final,
    output logic        out_valid,
    output logic [63:0] out_word,
    input  logic        out_ready,
    output logic        out_first,
    output logic        out_block_end,
    output logic        out_last,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, ABSORB, PAD_MARK, PAD_ZERO, PAD_LEN_HI, PAD_LEN_LO, FLUSH} state_t;
    state_t state_q, state_d;
    logic [63:0] acc_q, out_word_q, ld_word, mark_word;
    logic [LEN_W-1:0] len_q;
    logic [1:0] hw_cnt_q;
    logic [3:0] wcnt_q, pos;
    logic first_q, out_valid_q, out_first_q, out_block_end_q, out_last_q;
    logic hs, free, accept, load;

    always_comb begin
        hs = out_valid_q && out_ready;
        free = !out_valid_q || out_ready;
        in_ready = (state_q == ABSORB) && (hw_cnt_q != 2'd3 || free);
        accept = in_valid && in_ready;
        // a loaded word follows the held one only when that one is leaving this cycle
        pos = out_valid_q ? wcnt_q + 4'd1 : wcnt_q;
        mark_word = hw_cnt_q == 2'd0 ? {16'h8000, 48'h0} :
                    hw_cnt_q == 2'd1 ? {acc_q[63:48], 16'h8000, 32'h0} :
                    hw_cnt_q == 2'd2 ? {acc_q[63:32], 16'h8000, 16'h0} :
                                       {acc_q[63:16], 16'h8000};
        state_d = state_q;
        load = 1'b0;
        ld_word = 64'h0;
        case (state_q)
            IDLE: state_d = start ? ABSORB : IDLE;
            ABSORB: begin
                load = accept && hw_cnt_q == 2'd3;
                ld_word = {acc_q[63:16], in_data};
                state_d = in_final ? PAD_MARK : ABSORB;
            end
            PAD_MARK: begin
                load = free;
                ld_word = mark_word;
                state_d = !free ? PAD_MARK : pos == 4'd13 ? PAD_LEN_HI : PAD_ZERO;
            end
            PAD_ZERO: begin
                load = free;
                state_d = free && pos == 4'd13 ? PAD_LEN_HI : PAD_ZERO;
            end
            PAD_LEN_HI: begin
                load = free;
                state_d = free ? PAD_LEN_LO : PAD_LEN_HI;
            end
            PAD_LEN_LO: begin
                load = free;
                ld_word = 64'(len_q);
                state_d = free ? FLUSH : PAD_LEN_LO;
            end
            FLUSH: state_d = hs ? IDLE : FLUSH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q <= 64'h0;
            len_q <= '0;
            hw_cnt_q <= 2'd0;
            wcnt_q <= 4'd0;
            first_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q <= 64'h0;
            out_first_q <= 1'b0;
            out_block_end_q <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                len_q <= '0;
                hw_cnt_q <= 2'd0;
                wcnt_q <= 4'd0;
                first_q <= 1'b1;
            end
            if (accept) begin
                acc_q[{~hw_cnt_q, 4'b0} +: 16] <= in_data;
                hw_cnt_q <= hw_cnt_q + 2'd1;
                len_q <= len_q + LEN_W'(16);
            end
            if (hs) begin
                out_valid_q <= 1'b0;
                wcnt_q <= wcnt_q + 4'd1;
                out_first_q <= 1'b0;
                out_block_end_q <= 1'b0;
                out_last_q <= 1'b0;
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_word_q <= ld_word;
                out_first_q <= first_q;
                out_block_end_q <= pos == 4'd15;
                out_last_q <= state_q == PAD_LEN_LO;
                first_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_word = out_word_q;
    assign out_first = out_first_q;
    assign out_block_end = out_block_end_q;
    assign out_last = out_last_q;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_omsp_sha512_padder.sv
// tb_omsp_sha512_padder: directed scenarios for the SHA-512 padder with hand-computed words.
module tb_omsp_sha512_padder;
    logic clk = 1'b0;
    logic rst, start, in_valid, in_final, out_ready;
    logic in_ready, out_valid, out_first, out_block_end, out_last, busy;
    logic [15:0] in_data;
    logic [63:0] out_word;
    int vec = 0;
    int err = 0;
    logic [63:0] cap_w [0:255];
    logic cap_f [0:255];
    logic cap_e [0:255];
    logic cap_l [0:255];
    int cap_n = 0;
    int acc_cnt = 0;
    logic [15:0] hw_msg [0:63];
    logic [63:0] exp_w [0:31];
    int exp_n;

    omsp_sha512_padder #(.LEN_W(20)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .in_final(in_final), .out_valid(out_valid), .out_word(out_word),
        .out_ready(out_ready), .out_first(out_first), .out_block_end(out_block_end),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && out_valid && out_ready && cap_n < 256) begin
            cap_w[cap_n] = out_word;
            cap_f[cap_n] = out_first;
            cap_e[cap_n] = out_block_end;
            cap_l[cap_n] = out_last;
            cap_n++;
        end

    always @(posedge clk)
        if (!rst && in_valid && in_ready) acc_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_final();
        in_final = 1'b1;
        step();
        in_final = 1'b0;
    endtask

    task automatic send_hw(input logic [15:0] d, input logic fin);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_final = fin;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        vec++;
        if (!ok) begin
            err++;
            $display("FAIL send_hw %h: in_ready got 0 for 64 cycles, want 1", d);
        end
        step();
        in_valid = 1'b0;
        in_final = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = !busy;
        end
        vec++;
        if (!done) begin
            err++;
            $display("FAIL wait_idle: busy got 1 after 300 cycles, want 0");
        end
        step();
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 32; i++) exp_w[i] = 64'h0;
    endtask

    // Independent padding reference: halfword stream + marker + zero fill + 64-bit length tail
    function automatic void build_model(input int n);
        logic [15:0] h [0:127];
        int tot;
        for (int i = 0; i < 128; i++) h[i] = 16'h0;
        for (int i = 0; i < n; i++) h[i] = hw_msg[i];
        h[n] = 16'h8000;
        tot = ((n + 1 + 8 + 63) / 64) * 64;
        {h[tot-4], h[tot-3], h[tot-2], h[tot-1]} = 64'(n * 16);
        exp_n = tot / 4;
        for (int i = 0; i < exp_n; i++) exp_w[i] = {h[4*i], h[4*i+1], h[4*i+2], h[4*i+3]};
    endfunction

    task automatic test_reset();
        vec++;
        if ({out_valid, out_first, out_block_end, out_last, busy, in_ready} !== 6'b0) begin
            err++;
            $display("FAIL reset_flags: got %b, want 000000",
                     {out_valid, out_first, out_block_end, out_last, busy, in_ready});
        end
        vec++;
        if (out_word !== 64'h0) begin
            err++;
            $display("FAIL reset_word: got %h, want 0", out_word);
        end
        rst = 1'b0;
        step();
        vec++;
        if ({out_valid, busy, in_ready, out_word} !== 67'h0) begin
            err++;
            $display("FAIL post_reset: got v%b b%b r%b w%h, want all 0", out_valid, busy, in_ready, out_word);
        end
    endtask

    task automatic test_empty();
        int b;
        b = cap_n;
        clear_exp();
        exp_w[0] = 64'h8000_0000_0000_0000;
        exp_n = 16;
        do_start();
        do_final();
        wait_idle();
        vec++;
        if (cap_n - b !== exp_n) begin
            err++;
            $display("FAIL empty count: got %0d, want %0d", cap_n - b, exp_n);
        end
        for (int i = 0; i < exp_n && b + i < cap_n; i++) begin
            vec++;
            if (cap_w[b+i] !== exp_w[i] || cap_f[b+i] !== (i == 0) || cap_e[b+i] !== (i % 16 == 15) || cap_l[b+i] !== (i == exp_n - 1)) begin
                err++;
                $display("FAIL empty w%0d: got %h f%b e%b l%b, want %h f%b e%b l%b", i, cap_w[b+i], cap_f[b+i], cap_e[b+i], cap_l[b+i], exp_w[i], i == 0, i % 16 == 15, i == exp_n - 1);
            end
        end
    endtask

    task automatic test_three_hw();
        int b;
        b = cap_n;
        clear_exp();
        exp_w[0] = 64'h1234_5678_9ABC_8000;
        exp_w[15] = 64'h30;
        exp_n = 16;
        do_start();
        send_hw(16'h1234, 1'b0);
        send_hw(16'h5678, 1'b0);
        send_hw(16'h9ABC, 1'b0);
        do_final();
        wait_idle();
        vec++;
        if (cap_n - b !== exp_n) begin
            err++;
            $display("FAIL three_hw count: got %0d, want %0d", cap_n - b, exp_n);
        end
        for (int i = 0; i < exp_n && b + i < cap_n; i++) begin
            vec++;
            if (cap_w[b+i] !== exp_w[i] || cap_f[b+i] !== (i == 0) || cap_e[b+i] !== (i % 16 == 15) || cap_l[b+i] !== (i == exp_n - 1)) begin
                err++;
                $display("FAIL three_hw w%0d: got %h f%b e%b l%b, want %h f%b e%b l%b", i, cap_w[b+i], cap_f[b+i], cap_e[b+i], cap_l[b+i], exp_w[i], i == 0, i % 16 == 15, i == exp_n - 1);
            end
        end
    endtask

    task automatic test_two_blocks();
        int b;
        b = cap_n;
        clear_exp();
        for (int i = 0; i < 14; i++) exp_w[i] = 64'hA5A5_A5A5_A5A5_A5A5;
        exp_w[14] = 64'h8000_0000_0000_0000;
        exp_w[31] = 64'h380;
        exp_n = 32;
        do_start();
        for (int i = 0; i < 56; i++) send_hw(16'hA5A5, 1'b0);
        do_final();
        wait_idle();
        vec++;
        if (cap_n - b !== exp_n) begin
            err++;
            $display("FAIL two_blocks count: got %0d, want %0d", cap_n - b, exp_n);
        end
        for (int i = 0; i < exp_n && b + i < cap_n; i++) begin
            vec++;
            if (cap_w[b+i] !== exp_w[i] || cap_f[b+i] !== (i == 0) || cap_e[b+i] !== (i % 16 == 15) || cap_l[b+i] !== (i == exp_n - 1)) begin
                err++;
                $display("FAIL two_blocks w%0d: got %h f%b e%b l%b, want %h f%b e%b l%b", i, cap_w[b+i], cap_f[b+i], cap_e[b+i], cap_l[b+i], exp_w[i], i == 0, i % 16 == 15, i == exp_n - 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int b, ba;
        logic pv;
        logic [63:0] pw;
        b = cap_n;
        ba = acc_cnt;
        pv = 1'b0;
        pw = 64'h0;
        for (int i = 0; i < 22; i++) hw_msg[i] = 16'h1000 + 16'(i * 257);
        build_model(22);
        do_start();
        fork
            begin
                for (int i = 0; i < 22; i++) send_hw(hw_msg[i], 1'b0);
                do_final();
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    out_ready = (c % 8) >= 5;
                    @(negedge clk);
                    #1;
                    if (pv) begin
                        vec++;
                        if (out_valid !== 1'b1 || out_word !== pw) begin
                            err++;
                            $display("FAIL bp_hold c%0d: got v%b %h, want v1 %h", c, out_valid, out_word, pw);
                        end
                    end
                    if (!out_ready && out_valid && in_valid && (acc_cnt - ba) % 4 == 3) begin
                        vec++;
                        if (in_ready !== 1'b0) begin
                            err++;
                            $display("FAIL bp_in_ready c%0d: got %b, want 0", c, in_ready);
                        end
                    end
                    pv = out_valid && !out_ready;
                    pw = out_word;
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        wait_idle();
        vec++;
        if (cap_n - b !== exp_n) begin
            err++;
            $display("FAIL bp count: got %0d, want %0d", cap_n - b, exp_n);
        end
        for (int i = 0; i < exp_n && b + i < cap_n; i++) begin
            vec++;
            if (cap_w[b+i] !== exp_w[i] || cap_f[b+i] !== (i == 0) || cap_e[b+i] !== (i % 16 == 15) || cap_l[b+i] !== (i == exp_n - 1)) begin
                err++;
                $display("FAIL bp w%0d: got %h f%b e%b l%b, want %h f%b e%b l%b", i, cap_w[b+i], cap_f[b+i], cap_e[b+i], cap_l[b+i], exp_w[i], i == 0, i % 16 == 15, i == exp_n - 1);
            end
        end
    endtask

    task automatic test_final_with_data();
        int b;
        b = cap_n;
        clear_exp();
        exp_w[0] = 64'h0001_0002_0003_DEAD;
        exp_w[1] = 64'h8000_0000_0000_0000;
        exp_w[15] = 64'h40;
        exp_n = 16;
        do_start();
        send_hw(16'h0001, 1'b0);
        send_hw(16'h0002, 1'b0);
        send_hw(16'h0003, 1'b0);
        send_hw(16'hDEAD, 1'b1);
        wait_idle();
        vec++;
        if (cap_n - b !== exp_n) begin
            err++;
            $display("FAIL final_data count: got %0d, want %0d", cap_n - b, exp_n);
        end
        for (int i = 0; i < exp_n && b + i < cap_n; i++) begin
            vec++;
            if (cap_w[b+i] !== exp_w[i] || cap_f[b+i] !== (i == 0) || cap_e[b+i] !== (i % 16 == 15) || cap_l[b+i] !== (i == exp_n - 1)) begin
                err++;
                $display("FAIL final_data w%0d: got %h f%b e%b l%b, want %h f%b e%b l%b", i, cap_w[b+i], cap_f[b+i], cap_e[b+i], cap_l[b+i], exp_w[i], i == 0, i % 16 == 15, i == exp_n - 1);
            end
        end
    endtask

    task automatic test_reset_mid_pad();
        int b;
        do_start();
        do_final();
        repeat (4) step();
        rst = 1'b1;
        step();
        vec++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin
            err++;
            $display("FAIL mid_pad_reset: got v%b b%b r%b, want 000", out_valid, busy, in_ready);
        end
        rst = 1'b0;
        b = cap_n;
        do_final();
        repeat (20) step();
        vec++;
        if (cap_n - b !== 0 || busy !== 1'b0) begin
            err++;
            $display("FAIL final_no_start: got %0d words busy %b, want 0 words busy 0", cap_n - b, busy);
        end
        test_empty();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_final = 1'b0;
        in_data = 16'h0;
        out_ready = 1'b1;
        repeat (2) step();
        test_reset();
        test_empty();
        test_three_hw();
        test_two_blocks();
        test_backpressure();
        test_final_with_data();
        test_reset_mid_pad();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
